exe_muldiv_iter: RTL and testbench

//  Iterative M-extension unit in the execute stage. Takes MUL/MULH/MULHSU/DIV/REM
//  (AluSel plus SignSel from the decoded Ctrl) with both operands. Returns the result
//  to the EXE->MEM writeback path over a valid/ready handshake.

---
 rtl/exe_muldiv_iter_pkg.sv | 25 ++
 rtl/exe_muldiv_iter_signfix.sv | 42 ++++
 rtl/exe_muldiv_iter.sv | 153 +++++++++++++++
 tb/tb_exe_muldiv_iter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_muldiv_iter_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Operation selectors, FSM state type and opcode classification helpers.
package exe_muldiv_iter_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned MD_LAT       = XLEN_DEFAULT + 2;

  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX, MD_DONE} MdState;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM
  } AluSel;

  typedef enum logic {OP_UNSIGNED = 1'b0, OP_SIGNED = 1'b1} SignSel;

  function automatic logic is_m_op(AluSel s);
    return s inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction

  function automatic logic is_div_op(AluSel s);
    return s inside {ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/exe_muldiv_iter_signfix.sv
// Combinational sign handling: operand magnitudes, result sign and the
// final two's-complement correction of the unsigned datapath result.
module muldiv_signfix
  import exe_muldiv_iter_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  AluSel                 sel,
  input  SignSel                sign,
  input  logic [XLEN-1:0]       op1,
  input  logic [XLEN-1:0]       op2,
  output logic [XLEN-1:0]       abs1,
  output logic [XLEN-1:0]       abs2,
  output logic                  res_neg,
  input  logic [2*XLEN-1:0]     res_in,
  input  logic                  res_flip,
  output logic [2*XLEN-1:0]     res_out
);

  logic sgn1_en, sgn2_en, s1, s2;

  always_comb begin
    sgn1_en = 1'b0;
    sgn2_en = 1'b0;
    case (sel)
      ALU_MULH, ALU_DIV, ALU_REM: begin
        sgn1_en = (sign == OP_SIGNED);
        sgn2_en = (sign == OP_SIGNED);
      end
      ALU_MULHSU: sgn1_en = 1'b1;
      default: ;
    endcase
    s1      = sgn1_en & op1[XLEN-1];
    s2      = sgn2_en & op2[XLEN-1];
    abs1    = s1 ? -op1 : op1;
    abs2    = s2 ? -op2 : op2;
    // Remainder follows the dividend; products and quotients follow the sign xor.
    res_neg = (sel == ALU_REM) ? s1 : (s1 ^ s2);
    res_out = res_flip ? -res_in : res_in;
  end

endmodule

// File: rtl/exe_muldiv_iter.sv
// Iterative M-extension unit: radix-2 shift-add multiply and restoring
// divide over one shared register set, with valid/ready on both sides.
module exe_muldiv_iter
  import exe_muldiv_iter_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  AluSel            in_sel,
  input  SignSel           in_sign,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  MdState state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [XLEN-1:0]   hi, lo, mcand;
  AluSel             sel_q;
  logic              res_neg_q;

  logic              accept, div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_data, abs1, abs2, result;
  logic              res_neg;
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;

  assign in_ready  = (state == MD_IDLE);
  assign out_valid = (state == MD_DONE);
  assign busy      = (state != MD_IDLE);
  assign accept    = in_valid && in_ready && !kill;

  assign div_zero  = is_div_op(in_sel) && (in_op2 == '0);
  assign div_ovf   = is_div_op(in_sel) && (in_sign == OP_SIGNED) &&
                     (in_op1 == MIN_VAL) && (in_op2 == '1);
  assign fast      = div_zero || div_ovf;

  always_comb begin
    fast_data = '0;
    if (div_zero)
      fast_data = (in_sel == ALU_DIV) ? '1 : in_op1;
    else if (in_sel == ALU_DIV)
      fast_data = MIN_VAL;
  end

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .sel      (in_sel),
    .sign     (in_sign),
    .op1      (in_op1),
    .op2      (in_op2),
    .abs1     (abs1),
    .abs2     (abs2),
    .res_neg  (res_neg),
    .res_in   (fix_in),
    .res_flip (res_neg_q),
    .res_out  (fix_out)
  );

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_sh   = {hi, lo[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand};
    fix_in   = {hi, lo};
    if (is_div_op(sel_q))
      fix_in = {{XLEN{1'b0}}, (sel_q == ALU_REM) ? hi : lo};
    case (sel_q)
      ALU_MUL, ALU_DIV, ALU_REM: result = fix_out[XLEN-1:0];
      ALU_MULH, ALU_MULHSU:      result = fix_out[2*XLEN-1:XLEN];
      default:                   result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MD_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: if (accept) state_nxt = fast ? MD_DONE : MD_CALC;
        MD_CALC: if (count == CNT_W'(1)) state_nxt = MD_FIX;
        MD_FIX:  state_nxt = MD_DONE;
        MD_DONE: if (out_ready) state_nxt = MD_IDLE;
        default: state_nxt = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      hi        <= '0;
      lo        <= '0;
      mcand     <= '0;
      sel_q     <= ALU_ADD;
      res_neg_q <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (!kill) begin
      case (state)
        MD_IDLE: if (accept) begin
          out_tag   <= in_tag;
          sel_q     <= in_sel;
          res_neg_q <= res_neg;
          count     <= CNT_W'(XLEN);
          hi        <= '0;
          // Divide keeps the dividend in lo; multiply keeps the multiplier there.
          mcand     <= is_div_op(in_sel) ? abs2 : abs1;
          lo        <= is_div_op(in_sel) ? abs1 : abs2;
          if (fast) out_data <= fast_data;
        end
        MD_CALC: begin
          count <= count - 1'b1;
          if (is_div_op(sel_q)) begin
            if (!div_diff[XLEN]) begin
              hi <= div_diff[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= div_sh[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
        end
        MD_FIX:  out_data <= result;
        default: ;
      endcase
    end
  end

  a_m_op_only: assert property (@(posedge clk) disable iff (!reset_n)
                                in_valid |-> is_m_op(in_sel));

endmodule

// File: tb/tb_exe_muldiv_iter.sv
// Self-checking bench for exe_muldiv_iter at XLEN=32: directed corner cases
// plus randomized ops against an arithmetic reference model.
module tb_exe_muldiv_iter;
  import exe_muldiv_iter_pkg::*;

  localparam int unsigned XL = 32;

  logic          clk = 1'b0;
  logic          reset_n, kill, in_valid, out_ready;
  AluSel         in_sel;
  SignSel        in_sign;
  logic [XL-1:0] in_op1, in_op2, out_data;
  logic [7:0]    in_tag, out_tag;
  logic          in_ready, out_valid, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  typedef struct {
    logic [XL-1:0] data;
    logic [7:0]    tag;
    int            acc;
    int            lat;
    bit            seen;
  } exp_t;
  exp_t q[$];

  exe_muldiv_iter #(.XLEN(XL), .TAG_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .kill(kill), .in_valid(in_valid),
    .in_ready(in_ready), .in_sel(in_sel), .in_sign(in_sign),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [XL-1:0] model(AluSel s, SignSel g, logic [XL-1:0] a, logic [XL-1:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (s)
      ALU_MUL: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      ALU_MULH: begin
        if (g == OP_SIGNED) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else                p = {32'd0, a} * {32'd0, b};
        return p[63:32];
      end
      ALU_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      ALU_DIV: begin
        if (b == 0) return '1;
        if (g == OP_SIGNED) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
          return 32'(sa / sb);
        end
        return a / b;
      end
      ALU_REM: begin
        if (b == 0) return a;
        if (g == OP_SIGNED) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
          return 32'(sa % sb);
        end
        return a % b;
      end
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(AluSel s, SignSel g, logic [XL-1:0] a, logic [XL-1:0] b);
    if ((s == ALU_DIV || s == ALU_REM) &&
        (b == 0 || (g == OP_SIGNED && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return XL + 2;
  endfunction

  // Compare process: every cycle the outputs are defined.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
    end else begin
      chk("busy_vs_ready", 64'(busy), 64'(!in_ready));
      if (out_valid) begin
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: out_valid=1 data=%0h tag=%0h with nothing outstanding (cycle %0d)",
                   out_data, out_tag, cyc);
        end else begin
          chk("out_data", 64'(out_data), 64'(q[0].data));
          chk("out_tag", 64'(out_tag), 64'(q[0].tag));
          if (!q[0].seen) begin
            chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            q[0].seen = 1'b1;
          end
          if (out_ready && !kill) void'(q.pop_front());
        end
      end
      if (kill) q.delete();
    end
  end

  task automatic issue(AluSel s, SignSel g, logic [XL-1:0] a, logic [XL-1:0] b,
                       logic [7:0] t, logic with_kill, logic use_lit, logic [XL-1:0] lit);
    exp_t e;
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sel = s; in_sign = g; in_op1 = a; in_op2 = b; in_tag = t;
    kill = with_kill;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
    end else if (!with_kill) begin
      e.data = model(s, g, a, b);
      e.tag  = t;
      e.acc  = cyc;
      e.lat  = model_lat(s, g, a, b);
      e.seen = 1'b0;
      q.push_back(e);
    end
    if (use_lit) chk("model_pin", 64'(model(s, g, a, b)), 64'(lit));
    @(posedge clk); #1;
    in_valid = 1'b0;
    kill = 1'b0;
    in_op1 = $urandom;
    in_op2 = $urandom;
    in_tag = 8'($urandom);
  endtask

  task automatic pulse_kill();
    @(posedge clk); #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    chk("kill_out_valid", 64'(out_valid), 64'd0);
    chk("kill_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: out_valid never rose", name);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
      q.delete();
    end
  endtask

  function automatic logic [XL-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return XL'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  AluSel sels[5] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};

  initial begin
    reset_n = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sel = ALU_MUL; in_sign = OP_SIGNED; in_op1 = '0; in_op2 = '0; in_tag = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Directed values with hand-computed results
    issue(ALU_MUL, OP_SIGNED, 32'd7, 32'hFFFF_FFFD, 8'h11, 0, 1, 32'hFFFF_FFEB);
    issue(ALU_MULH, OP_SIGNED, 32'h8000_0000, 32'h8000_0000, 8'h12, 0, 1, 32'h4000_0000);
    issue(ALU_MULHSU, OP_SIGNED, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h21, 0, 1, 32'hFFFF_FFFF);
    issue(ALU_MULH, OP_UNSIGNED, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h22, 0, 1, 32'hFFFF_FFFE);
    issue(ALU_DIV, OP_SIGNED, 32'hFFFF_FFF9, 32'd2, 8'h31, 0, 1, 32'hFFFF_FFFD);
    issue(ALU_REM, OP_SIGNED, 32'hFFFF_FFF9, 32'd2, 8'h32, 0, 1, 32'hFFFF_FFFF);
    issue(ALU_DIV, OP_UNSIGNED, 32'hFFFF_FFF9, 32'd2, 8'h33, 0, 1, 32'h7FFF_FFFC);
    issue(ALU_DIV, OP_SIGNED, 32'd5, 32'd0, 8'h41, 0, 1, 32'hFFFF_FFFF);
    issue(ALU_REM, OP_UNSIGNED, 32'd5, 32'd0, 8'h42, 0, 1, 32'd5);
    issue(ALU_DIV, OP_SIGNED, 32'h8000_0000, 32'hFFFF_FFFF, 8'h43, 0, 1, 32'h8000_0000);
    issue(ALU_REM, OP_SIGNED, 32'h8000_0000, 32'hFFFF_FFFF, 8'h44, 0, 1, 32'd0);
    drain();

    // Backpressure: result held for 10 cycles, then a single transfer
    ready_mode = 0;
    issue(ALU_MULHSU, OP_UNSIGNED, 32'h8000_0001, 32'hDEAD_BEEF, 8'h51, 0, 0, '0);
    wait_valid("hold_valid");
    repeat (10) @(posedge clk);
    ready_mode = 1;
    drain();
    repeat (5) @(posedge clk);

    // Kill mid-CALC, in DONE, and together with an accept
    issue(ALU_DIV, OP_UNSIGNED, 32'd1000, 32'd7, 8'h61, 0, 0, '0);
    repeat (10) @(posedge clk);
    pulse_kill();
    repeat (40) @(posedge clk);
    ready_mode = 0;
    issue(ALU_MUL, OP_SIGNED, 32'd9, 32'd9, 8'h62, 0, 0, '0);
    wait_valid("kill_done_valid");
    pulse_kill();
    ready_mode = 1;
    repeat (5) @(posedge clk);
    issue(ALU_REM, OP_SIGNED, 32'd77, 32'd5, 8'h63, 1, 0, '0);
    chk("kill_accept_busy", 64'(busy), 64'd0);
    repeat (40) @(posedge clk);

    // Reset mid-CALC
    issue(ALU_MULH, OP_SIGNED, 32'h1234_5678, 32'h9ABC_DEF0, 8'h71, 0, 0, '0);
    repeat (12) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(posedge clk);

    // Randomized ops with random output backpressure
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      issue(sels[$urandom_range(0, 4)], SignSel'($urandom_range(0, 1)),
            rand_opnd(), rand_opnd(), 8'($urandom), 0, 0, '0);
    end
    ready_mode = 1;
    drain();
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
